intercal_alu_sequencer: RTL and testbench

//  Command front-end directly upstream of the INTERCAL ALU (s/a/b -> f, combinational).

---
 rtl/intercal_alu_sequencer.sv | 122 ++++++++++++
 tb/tb_intercal_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intercal_alu_sequencer.sv
// Command front-end for the combinational INTERCAL ALU: fetches operands, registers s/a/b,
// classifies the ALU result, writes it back to the register file and returns a response.
module intercal_alu_sequencer #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic          cmd_useimm,
    input  logic [31:0]   cmd_imm,
    output logic [3:0]    alu_s,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    input  logic [31:0]   alu_f,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    output logic [1:0]    rsp_code
);

    localparam int NREG = 2 ** AW;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // cmd_ready depends only on state; rsp_valid and rsp_* stay stable until rsp_ready.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          accept;
    logic          err;
    logic [1:0]    code;
    logic [3:0]    op_q;
    logic [AW-1:0] dst_q;
    logic [31:0]   rd_a, rd_b;
    logic [31:0]   regs [NREG];

    // r0 is hard-wired to zero on read; it is also never written.
    assign rd_a = (cmd_srca == '0) ? 32'd0 : regs[cmd_srca];
    assign rd_b = (cmd_srcb == '0) ? 32'd0 : regs[cmd_srcb];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (cmd_valid) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error classification uses the latched op and the operands already on the ALU bus.
    always_comb begin
        err  = 1'b0;
        code = 2'd0;
        if (op_q >= 4'd12) begin
            err  = 1'b1;
            code = 2'd1;
        end else if (op_q == 4'd8 && (alu_a[31:16] | alu_b[31:16]) != 16'd0) begin
            err  = 1'b1;
            code = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s    <= 4'd0;
            alu_a    <= 32'd0;
            alu_b    <= 32'd0;
            op_q     <= 4'd0;
            dst_q    <= '0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
            rsp_code <= 2'd0;
        end else if (accept) begin
            alu_s <= (cmd_op >= 4'd12) ? 4'd0 : cmd_op;
            alu_a <= rd_a;
            alu_b <= cmd_useimm ? cmd_imm : rd_b;
            op_q  <= cmd_op;
            dst_q <= cmd_dst;
        end else if (state_q == ST_EXEC) begin
            rsp_data <= err ? 32'd0 : alu_f;
            rsp_err  <= err;
            rsp_code <= code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 32'd0;
        end else if (state_q == ST_EXEC && !err && dst_q != '0) begin
            regs[dst_q] <= alu_f;
        end
    end

endmodule

// File: tb/tb_intercal_alu_sequencer.sv
// Bench for intercal_alu_sequencer: a behavioural ALU drives alu_f, and a register-file
// model predicts every response, writeback and error code.
module tb_intercal_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_dst, cmd_srca, cmd_srcb;
    logic        cmd_useimm;
    logic [31:0] cmd_imm;
    logic [3:0]  alu_s;
    logic [31:0] alu_a, alu_b, alu_f;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  rsp_code;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mreg [8];
    logic [31:0] last_data;
    logic        last_err;
    logic [1:0]  last_code;

    always #5 clk = ~clk;

    intercal_alu_sequencer #(.AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_useimm(cmd_useimm), .cmd_imm(cmd_imm),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_code(rsp_code)
    );

    // Stand-in ALU: 0 pass A, 1 pass B, 2..7 unary, 8/9 mingle low/high halves, 10 xor, 11 select.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] rot;
        int k;
        r   = 32'd0;
        rot = {a[0], a[31:1]};
        case (op)
            4'd0:  r = a;
            4'd1:  r = b;
            4'd2:  r = ~a;
            4'd3:  r = rot;
            4'd4:  r = a & rot;
            4'd5:  r = a | rot;
            4'd6:  r = a ^ rot;
            4'd7:  r = a << 1;
            4'd8:  for (int i = 0; i < 16; i++) begin r[2*i+1] = a[i]; r[2*i] = b[i]; end
            4'd9:  for (int i = 0; i < 16; i++) begin r[2*i+1] = a[16+i]; r[2*i] = b[16+i]; end
            4'd10: r = a ^ b;
            4'd11: begin
                k = 0;
                for (int i = 0; i < 32; i++) if (b[i]) begin r[k] = a[i]; k++; end
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign alu_f = alu_ref(alu_s, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cmd();
        cmd_op     = 4'($urandom);
        cmd_dst    = 3'($urandom);
        cmd_srca   = 3'($urandom);
        cmd_srcb   = 3'($urandom);
        cmd_useimm = 1'($urandom);
        cmd_imm    = $urandom;
    endtask

    // One full transaction; the expected response comes from the register model, not the DUT.
    task automatic run_cmd(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] srca,
                           input logic [2:0] srcb, input logic useimm, input logic [31:0] imm,
                           input int hold);
        logic [31:0] ea, eb, ed;
        logic [1:0]  ec;
        int n;
        ea = mreg[srca];
        eb = useimm ? imm : mreg[srcb];
        if (op >= 4'd12) ec = 2'd1;
        else if (op == 4'd8 && ((ea | eb) >> 16) != 32'd0) ec = 2'd2;
        else ec = 2'd0;
        ed = (ec == 2'd0) ? alu_ref(op, ea, eb) : 32'd0;

        @(negedge clk);
        cmd_op = op; cmd_dst = dst; cmd_srca = srca; cmd_srcb = srcb;
        cmd_useimm = useimm; cmd_imm = imm; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("accept_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble_cmd();
        check("exec_alu_s", alu_s, (op >= 4'd12) ? 4'd0 : op);
        check("exec_alu_a", alu_a, ea);
        check("exec_alu_b", alu_b, eb);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, ed);
        check("rsp_err", rsp_err, (ec != 2'd0));
        check("rsp_code", rsp_code, ec);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, ed);
            check("hold_code", rsp_code, ec);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("done_valid", rsp_valid, 0);
        check("done_cmd_ready", cmd_ready, 1);
        if (ec == 2'd0 && dst != 3'd0) mreg[dst] = ed;
        last_data = ed;
        last_err  = (ec != 2'd0);
        last_code = ec;
        last_data = rsp_data;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        scramble_cmd();
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_s", alu_s, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_code", rsp_code, 0);

        // load constant, then copy through op 0
        run_cmd(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0000_00FF, 0);
        check("t1_load", last_data, 32'h0000_00FF);
        run_cmd(4'd0, 3'd2, 3'd1, 3'd0, 1'b0, 32'h0, 0);
        check("t1_copy", last_data, 32'h0000_00FF);

        // legal mingle, then read back the destination
        run_cmd(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0000_FFFF, 0);
        run_cmd(4'd1, 3'd2, 3'd0, 3'd0, 1'b1, 32'h0000_0000, 0);
        run_cmd(4'd8, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0, 1);
        check("t2_mingle", last_data, 32'hAAAA_AAAA);
        run_cmd(4'd0, 3'd5, 3'd3, 3'd0, 1'b0, 32'h0, 0);
        check("t2_r3", last_data, 32'hAAAA_AAAA);

        // mingle with an operand wider than 16 bits: no writeback
        run_cmd(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0001_0000, 0);
        run_cmd(4'd8, 3'd3, 3'd1, 3'd0, 1'b0, 32'h0, 0);
        check("t3_err", last_err, 1);
        check("t3_code", last_code, 2);
        run_cmd(4'd0, 3'd5, 3'd3, 3'd0, 1'b0, 32'h0, 0);
        check("t3_r3_kept", last_data, 32'hAAAA_AAAA);

        // select
        run_cmd(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 32'h1234_5678, 0);
        run_cmd(4'd11, 3'd6, 3'd1, 3'd0, 1'b1, 32'h0000_FF00, 0);
        check("t4_select", last_data, 32'h0000_0056);

        // illegal op held in RESP, plus a write attempt to r0
        run_cmd(4'd13, 3'd6, 3'd1, 3'd2, 1'b0, 32'h0, 5);
        check("t5_code", last_code, 1);
        run_cmd(4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 0);
        run_cmd(4'd0, 3'd7, 3'd0, 3'd0, 1'b0, 32'h0, 0);
        check("r0_reads_zero", last_data, 32'h0);

        // randomized traffic against the register model
        for (int t = 0; t < 60; t++) begin
            logic [31:0] imm;
            imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 65535));
            run_cmd(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
                    1'($urandom), imm, $urandom_range(0, 3));
        end
        for (int r = 0; r < 8; r++) begin
            run_cmd(4'd0, 3'd0, 3'(r), 3'd0, 1'b0, 32'h0, 0);
        end

        // reset while the command is in EXEC: aborted, registers cleared
        @(negedge clk);
        cmd_op = 4'd1; cmd_dst = 3'd4; cmd_srca = 3'd0; cmd_srcb = 3'd0;
        cmd_useimm = 1'b1; cmd_imm = 32'hDEAD_BEEF; cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("t6_in_exec", cmd_ready, 0);
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_alu_s", alu_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t6_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;
        run_cmd(4'd0, 3'd0, 3'd4, 3'd0, 1'b0, 32'h0, 0);
        check("t6_r4_zero", last_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
